// File: rtl/gamma_loader_if.sv
// Download port between the HPS IO block and the gamma loader.
// master = HPS download side, slave = gamma_loader.
interface gamma_loader_if;
  logic        dl_active;
  logic        dl_wr;
  logic [8:0]  dl_addr;
  logic [15:0] dl_data;
  logic        dl_wait;

  modport master (
    output dl_active,
    output dl_wr,
    output dl_addr,
    output dl_data,
    input  dl_wait
  );

  modport slave (
    input  dl_active,
    input  dl_wr,
    input  dl_addr,
    input  dl_data,
    output dl_wait
  );
endinterface

// File: rtl/gamma_loader.sv
// gamma_loader: turns the 16-bit HPS download stream into byte writes for the gamma LUT
// and owns the effective gamma enable. Define GAMMA_INIT_EN to load an identity curve after reset.
module gamma_loader #(
  parameter int ENTRIES    = 256,
  parameter int WORDS_FULL = 128
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          gamma_req,
  gamma_loader_if.slave dl,
  output logic          gamma_wr,
  output logic [7:0]    gamma_wr_addr,
  output logic [7:0]    gamma_value,
  output logic          gamma_en,
  output logic          table_valid,
  output logic          overrun
);

  localparam int IDX_W = $clog2(ENTRIES + 1);
  localparam int CNT_W = $clog2(WORDS_FULL + 1);
  localparam logic [9:0]       ENTRIES_W = 10'(ENTRIES);
  localparam logic [IDX_W-1:0] INIT_END  = IDX_W'(ENTRIES);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WORDS_FULL);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_WR_HI = 2'd2
  } state_t;

`ifdef GAMMA_INIT_EN
  localparam state_t RST_STATE = S_INIT;
  localparam logic   RST_WAIT  = 1'b1;
`else
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_WAIT  = 1'b0;
`endif

  state_t           state_r, state_nxt_s;
  logic             wr_r, wr_nxt_s;
  logic [7:0]       addr_r, addr_nxt_s;
  logic [7:0]       value_r, value_nxt_s;
  logic [7:0]       hi_byte_r, hi_nxt_s;
  logic             wait_r, wait_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             ovr_r, ovr_nxt_s;
  logic             en_r, en_nxt_s;
  logic             act_r;
  logic [IDX_W-1:0] init_cnt_r, init_nxt_s;
  logic             pend_rise_r, pend_nxt_s;

  logic             rise_s;
  logic             fall_s;
  logic             addr_ok_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] cnt_post_s;
  logic             addr_lsb_unused_s;

  assign rise_s            = dl.dl_active & ~act_r;
  assign fall_s            = ~dl.dl_active & act_r;
  assign addr_ok_s         = ({1'b0, dl.dl_addr[8:1], 1'b0} < ENTRIES_W);
  assign cnt_inc_s         = (cnt_r == FULL_CNT) ? cnt_r : cnt_r + CNT_W'(1);
  // A falling edge while the high byte is pending judges the table on the post-increment count.
  assign cnt_post_s        = (state_r == S_WR_HI) ? cnt_inc_s : cnt_r;
  assign addr_lsb_unused_s = dl.dl_addr[0];

  // Next-state and next-output computation for every register
  always_comb begin
    state_nxt_s = state_r;
    wr_nxt_s    = 1'b0;
    addr_nxt_s  = addr_r;
    value_nxt_s = value_r;
    hi_nxt_s    = hi_byte_r;
    wait_nxt_s  = wait_r;
    cnt_nxt_s   = cnt_r;
    valid_nxt_s = valid_r;
    ovr_nxt_s   = ovr_r;
    init_nxt_s  = init_cnt_r;
    pend_nxt_s  = pend_rise_r;
    en_nxt_s    = gamma_req & valid_r & ~act_r & (state_r != S_INIT);

    if (rise_s) begin
      cnt_nxt_s = '0;
      ovr_nxt_s = 1'b0;
      if (state_r == S_INIT) begin
        pend_nxt_s = 1'b1;
      end else begin
        valid_nxt_s = 1'b0;
      end
    end else if (fall_s) begin
      valid_nxt_s = (cnt_post_s == FULL_CNT);
    end else begin
      valid_nxt_s = valid_r;
    end

    case (state_r)
      S_INIT: begin
        ovr_nxt_s = ovr_nxt_s | dl.dl_wr;
        if (init_cnt_r == INIT_END) begin
          state_nxt_s = S_IDLE;
          wait_nxt_s  = 1'b0;
          valid_nxt_s = ~(pend_rise_r | rise_s);
          pend_nxt_s  = 1'b0;
        end else begin
          wr_nxt_s    = 1'b1;
          addr_nxt_s  = 8'(init_cnt_r);
          value_nxt_s = 8'(init_cnt_r);
          init_nxt_s  = init_cnt_r + IDX_W'(1);
          wait_nxt_s  = 1'b1;
        end
      end
      S_IDLE: begin
        if (dl.dl_wr && dl.dl_active && addr_ok_s) begin
          state_nxt_s = S_WR_HI;
          wr_nxt_s    = 1'b1;
          addr_nxt_s  = {dl.dl_addr[7:1], 1'b0};
          value_nxt_s = dl.dl_data[7:0];
          hi_nxt_s    = dl.dl_data[15:8];
          wait_nxt_s  = 1'b1;
        end else begin
          wait_nxt_s  = 1'b0;
        end
      end
      S_WR_HI: begin
        state_nxt_s = S_IDLE;
        wr_nxt_s    = 1'b1;
        addr_nxt_s  = addr_r + 8'd1;
        value_nxt_s = hi_byte_r;
        wait_nxt_s  = 1'b0;
        ovr_nxt_s   = ovr_nxt_s | dl.dl_wr;
        cnt_nxt_s   = rise_s ? '0 : cnt_inc_s;
      end
      default: begin
        state_nxt_s = S_IDLE;
        wait_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any pending write at once
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r     <= RST_STATE;
      wr_r        <= 1'b0;
      addr_r      <= 8'd0;
      value_r     <= 8'd0;
      hi_byte_r   <= 8'd0;
      wait_r      <= RST_WAIT;
      cnt_r       <= '0;
      valid_r     <= 1'b0;
      ovr_r       <= 1'b0;
      en_r        <= 1'b0;
      act_r       <= 1'b0;
      init_cnt_r  <= '0;
      pend_rise_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wr_r        <= wr_nxt_s;
      addr_r      <= addr_nxt_s;
      value_r     <= value_nxt_s;
      hi_byte_r   <= hi_nxt_s;
      wait_r      <= wait_nxt_s;
      cnt_r       <= cnt_nxt_s;
      valid_r     <= valid_nxt_s;
      ovr_r       <= ovr_nxt_s;
      en_r        <= en_nxt_s;
      act_r       <= dl.dl_active;
      init_cnt_r  <= init_nxt_s;
      pend_rise_r <= pend_nxt_s;
    end
  end

  assign gamma_wr      = wr_r;
  assign gamma_wr_addr = addr_r;
  assign gamma_value   = value_r;
  assign gamma_en      = en_r;
  assign table_valid   = valid_r;
  assign overrun       = ovr_r;
  assign dl.dl_wait    = wait_r;

endmodule
